// File: rtl/fp4_fft_output_streamer.sv
// Unloads an FFT result memory as a valid/ready stream of FP4 complex samples.
// Define FP4_FFT_STREAM_FFTSHIFT_EN to read in fftshift order (DC lands at index N/2).
module fp4_fft_output_streamer #(
  parameter int MAX_N      = 32,
  parameter int ADDR_WIDTH = $clog2(MAX_N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   N_config,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [7:0]            rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

  state_e                     state_q, state_d;
  logic [CW-1:0]              n_q, n_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [CW-1:0]              nm1;
  logic                       infl_q;
  logic [ADDR_WIDTH-1:0]      infl_idx_q;
  logic                       infl_last_q;
  logic [1:0][7:0]            buf_data_q;
  logic [1:0][ADDR_WIDTH-1:0] buf_idx_q;
  logic [1:0]                 buf_last_q;
  logic                       wr_ptr_q, rd_ptr_q;
  logic [1:0]                 count_q;
  logic                       done_q, done_d;
  logic                       cfg_err_q, cfg_err_d;

  logic                       cfg_ok;
  logic                       pop;
  logic [2:0]                 occ;
  logic                       issue;
  logic                       last_issue;
  logic                       last_out;
  logic [ADDR_WIDTH-1:0]      rd_idx;

  assign cfg_ok = (N_config >= CW'(2)) && (N_config <= CW'(MAX_N)) &&
                  ((N_config & (N_config - CW'(1))) == '0);

  assign nm1       = n_q - CW'(1);
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && out_ready;

  // A read issued now lands in the buffer next cycle, so the in-flight read
  // counts as occupied; a pop this cycle frees a slot in time for it.
  assign occ        = {1'b0, count_q} + {2'b00, infl_q};
  assign issue      = (state_q == STREAM) && ((occ <= 3'd1) || ((occ == 3'd2) && pop));
  assign last_issue = issue && (cnt_q == nm1);
  assign last_out   = pop && buf_last_q[rd_ptr_q];

`ifdef FP4_FFT_STREAM_FFTSHIFT_EN
  assign rd_idx = (cnt_q[ADDR_WIDTH-1:0] + n_q[ADDR_WIDTH:1]) & nm1[ADDR_WIDTH-1:0];
`else
  assign rd_idx = cnt_q[ADDR_WIDTH-1:0];
`endif

  assign rd_addr   = issue ? rd_idx : '0;
  assign out_data  = out_valid ? buf_data_q[rd_ptr_q] : '0;
  assign out_index = out_valid ? buf_idx_q[rd_ptr_q] : '0;
  assign out_last  = out_valid && buf_last_q[rd_ptr_q];
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            n_d     = N_config;
            cnt_d   = '0;
            state_d = STREAM;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (issue) begin
          cnt_d = cnt_q + CW'(1);
          if (last_issue) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_out) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      n_q       <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Two-entry output buffer fed by the read issued on the previous cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      infl_q      <= 1'b0;
      infl_idx_q  <= '0;
      infl_last_q <= 1'b0;
      buf_data_q  <= '0;
      buf_idx_q   <= '0;
      buf_last_q  <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      infl_q      <= issue;
      infl_idx_q  <= cnt_q[ADDR_WIDTH-1:0];
      infl_last_q <= last_issue;
      if (infl_q) begin
        buf_data_q[wr_ptr_q] <= rd_data;
        buf_idx_q[wr_ptr_q]  <= infl_idx_q;
        buf_last_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, infl_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fp4_fft_output_streamer.sv
// Randomized bench for fp4_fft_output_streamer against a sequence-level model.
// Build with FP4_FFT_STREAM_FFTSHIFT_EN to exercise the fftshift read order.
module tb_fp4_fft_output_streamer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] N_config;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [4:0] out_index;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       cfg_err;

  fp4_fft_output_streamer dut (
    .clk(clk), .rst(rst), .start(start), .N_config(N_config),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int readyMode = 0;

  logic [7:0] mem [0:31];

  logic [7:0] beatData[$];
  logic [4:0] beatIdx[$];
  logic       beatLast[$];
  int         beatCyc[$];
  int         doneCount, cfgErrCount;
  bit         busySeen, prevStall, lastPrev;
  logic [7:0] prevData;
  logic [4:0] prevIdx;
  logic       prevLast;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous result memory: data appears one cycle after the address.
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Beat collector plus stall-stability and done-timing checks.
  always @(negedge clk) begin
    if (!rst) begin
      prevStall = 1'b0;
      lastPrev  = 1'b0;
    end else begin
      if (done || lastPrev) begin
        checkOutput("done_timing", 32'(done), 32'(lastPrev));
        if (lastPrev) checkOutput("busy_after_done", 32'(busy), 32'(0));
      end
      lastPrev = 1'b0;
      if (prevStall) begin
        checkOutput("stall_valid", 32'(out_valid), 32'(1));
        checkOutput("stall_data", 32'(out_data), 32'(prevData));
        checkOutput("stall_index", 32'(out_index), 32'(prevIdx));
        checkOutput("stall_last", 32'(out_last), 32'(prevLast));
      end
      if (cfg_err) cfgErrCount++;
      if (busy) busySeen = 1'b1;
      if (done) doneCount++;
      if (out_valid && out_ready) begin
        beatData.push_back(out_data);
        beatIdx.push_back(out_index);
        beatLast.push_back(out_last);
        beatCyc.push_back(cyc);
        if (out_last) lastPrev = 1'b1;
      end
      prevStall = out_valid && !out_ready;
      prevData  = out_data;
      prevIdx   = out_index;
      prevLast  = out_last;
    end
  end

  function automatic int modelAddr(input int i, input int n);
`ifdef FP4_FFT_STREAM_FFTSHIFT_EN
    return (i + n / 2) % n;
`else
    return i;
`endif
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'(0));
    checkOutput({tag, "_data"}, 32'(out_data), 32'(0));
    checkOutput({tag, "_index"}, 32'(out_index), 32'(0));
    checkOutput({tag, "_last"}, 32'(out_last), 32'(0));
    checkOutput({tag, "_rdaddr"}, 32'(rd_addr), 32'(0));
    checkOutput({tag, "_busy"}, 32'(busy), 32'(0));
    checkOutput({tag, "_done"}, 32'(done), 32'(0));
    checkOutput({tag, "_cfgerr"}, 32'(cfg_err), 32'(0));
  endtask

  // fill = 0 gives random memory, otherwise mem[k] = fill + k.
  task automatic applyStimulus(input int n, input int rmode, input bit midStart,
                               input int resetAfter, input int fill);
    bit         validN;
    int         budget;
    logic [7:0] expData[$];
    validN = (n == 2) || (n == 4) || (n == 8) || (n == 16) || (n == 32);
    for (int k = 0; k < 32; k++) mem[k] = (fill == 0) ? 8'($urandom) : 8'(fill + k);
    expData.delete();
    if (validN) for (int i = 0; i < n; i++) expData.push_back(mem[modelAddr(i, n)]);
    beatData.delete(); beatIdx.delete(); beatLast.delete(); beatCyc.delete();
    doneCount = 0; cfgErrCount = 0; busySeen = 1'b0;
    readyMode = rmode;

    @(posedge clk); #1;
    N_config = 6'(n);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    if (!validN) begin
      repeat (6) @(negedge clk);
      #1;
      checkOutput("cfgerr_pulses", 32'(cfgErrCount), 32'(1));
      checkOutput("cfgerr_busy", 32'(busySeen), 32'(0));
      checkOutput("cfgerr_beats", 32'(beatData.size()), 32'(0));
      return;
    end

    @(negedge clk); #1;
    checkOutput("busy_c1", 32'(busy), 32'(1));
    checkOutput("valid_c1", 32'(out_valid), 32'(0));
    @(negedge clk); #1;
    checkOutput("valid_c2", 32'(out_valid), 32'(0));
    @(negedge clk); #1;
    checkOutput("valid_c3", 32'(out_valid), 32'(1));

    budget = n * 8 + 40;
    for (int k = 0; k < budget && doneCount == 0; k++) begin
      if (midStart && k == 4) begin
        start    = 1'b1;
        N_config = 6'd4;
      end else begin
        start = 1'b0;
      end
      @(negedge clk); #1;
      if (resetAfter > 0 && beatData.size() >= resetAfter) begin
        checkOutput("beats_before_reset", 32'(beatData.size()), 32'(resetAfter));
        rst = 1'b0;
        #1;
        checkAllZero("midreset");
        @(negedge clk); #2;
        rst = 1'b1;
        return;
      end
    end
    start = 1'b0;
    if (doneCount == 0) checkOutput("timeout", 32'(1), 32'(0));
    repeat (4) @(negedge clk);
    #1;

    checkOutput("beat_count", 32'(beatData.size()), 32'(n));
    checkOutput("done_count", 32'(doneCount), 32'(1));
    checkOutput("cfgerr_none", 32'(cfgErrCount), 32'(0));
    for (int i = 0; i < n && i < beatData.size(); i++) begin
      checkOutput("beat_data", 32'(beatData[i]), 32'(expData[i]));
      checkOutput("beat_index", 32'(beatIdx[i]), 32'(i));
      checkOutput("beat_last", 32'(beatLast[i]), 32'(i == n - 1));
    end
    if (rmode == 0 && beatCyc.size() == n)
      checkOutput("consecutive", 32'(beatCyc[n-1] - beatCyc[0]), 32'(n - 1));
  endtask

  initial begin
    int sizes[5];
    sizes = '{2, 4, 8, 16, 32};
    rst = 1'b0;
    start = 1'b0;
    N_config = '0;
    #3;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(8, 0, 1'b0, 0, 8'h10);
    applyStimulus(8, 1, 1'b0, 0, 0);
    applyStimulus(6, 0, 1'b0, 0, 0);
    applyStimulus(0, 0, 1'b0, 0, 0);
    applyStimulus(33, 0, 1'b0, 0, 0);
    applyStimulus(16, 0, 1'b0, 3, 0);
    applyStimulus(16, 0, 1'b0, 0, 0);
    applyStimulus(32, 2, 1'b1, 0, 0);
`ifdef FP4_FFT_STREAM_FFTSHIFT_EN
    applyStimulus(4, 0, 1'b0, 0, 8'hA0);
`endif
    for (int t = 0; t < 6; t++)
      applyStimulus(sizes[$urandom_range(0, 4)], int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
